// File: rtl/seq_arith_pkg.sv
// ---------------------------------------------------------------------------
// seq_arith_pkg
// Shared definitions for the sequential (chunk-serial) arithmetic blocks.
//   state_t  : control FSM states (IDLE / RUN / DONE)
//   MODE_ADD : mode value selecting A + B
//   MODE_SUB : mode value selecting A - B (A + ~B + 1)
// ---------------------------------------------------------------------------
package seq_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a chunk-index counter able to hold 0 .. nch-1 (never zero bits).
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_add_sub_slice.sv
// ---------------------------------------------------------------------------
// add_sub_slice
// Combinational CHUNK-bit adder slice shared by every cycle of seq_add_sub.
// Computes a + (b ^ {CHUNK{mode}}) + cin, so a subtract is formed by
// inverting b here and injecting the +1 through cin on the first chunk.
// Ports:
//   a, b      in  CHUNK  operand chunks
//   mode      in  1      0 = add, 1 = subtract (inverts b)
//   cin       in  1      carry in from the previous chunk
//   s         out CHUNK  sum chunk
//   cout      out 1      carry out of the slice MSB
//   c_msb_in  out 1      carry into the slice MSB (for overflow detection)
// ---------------------------------------------------------------------------
module add_sub_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] w_b_eff;
  logic [CHUNK:0]   w_full;

  assign w_b_eff = b ^ {CHUNK{mode}};
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{CHUNK{1'b0}}, cin};

  assign s    = w_full[CHUNK-1:0];
  assign cout = w_full[CHUNK];
  // The MSB sum bit is a ^ b ^ carry_in at that position, so the carry into
  // the MSB can be recovered from the sum without a second adder.
  assign c_msb_in = w_full[CHUNK-1] ^ a[CHUNK-1] ^ w_b_eff[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// ---------------------------------------------------------------------------
// seq_add_sub
// Multi-cycle WIDTH-bit adder/subtractor. Operands are captured on an
// accepted start and processed CHUNK bits per clock through one shared
// add_sub_slice, with the carry held in a register between cycles.
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, sampled only in IDLE or DONE
//   mode   in  1      0 = A+B, 1 = A-B, captured with start
//   a, b   in  WIDTH  operands, captured with start
//   busy   out 1      operation in progress
//   done   out 1      one-cycle pulse, result valid
//   sum    out WIDTH  result
//   cout   out 1      carry out of MSB (subtract: 1 = no borrow)
//   ovf    out 1      two's-complement overflow
// ---------------------------------------------------------------------------
module seq_add_sub
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = idx_width(NCH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_add_sub: WIDTH must be >= 2 and an exact multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb_in;

  // Operand registers shift right each RUN cycle, so the slice always sees
  // the current chunk in the low bits.
  add_sub_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a        (r_a[CHUNK-1:0]),
    .b        (r_b[CHUNK-1:0]),
    .mode     (r_mode),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= MODE_ADD;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            // The +1 of A + ~B + 1 enters as the first chunk's carry in.
            r_carry <= mode;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
          r_carry <= w_cout;
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c_msb_in ^ w_cout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            // busy is asserted after each non-final chunk edge; the cycle
            // right after capture reports not-busy, giving NCH-1 busy cycles.
            r_idx  <= r_idx + 1'b1;
            r_busy <= 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
